// File: rtl/mcs_pkg.sv
// -----------------------------------------------------------------------------
// mcs_pkg
// Shared definitions for the MUXDC configuration sequencer:
//   - default field widths for a layer descriptor
//   - FSM state encoding (IDLE, LOAD, CONF, WAIT_ACK, ACK, RUN)
//   - descriptor record {cols, rows} at the default widths
//   - watchdog counter width helper (used only when MCS_TIMEOUT_EN is defined)
// -----------------------------------------------------------------------------
package mcs_pkg;

   localparam int MCS_COLS_W_DEF   = 4;
   localparam int MCS_ROWS_W_DEF   = 4;
   localparam int MCS_W_SIZE_W_DEF = 9;
   localparam int MCS_DEPTH_DEF    = 4;

   typedef logic [2:0] mcs_state_t;

   localparam mcs_state_t ST_IDLE     = 3'd0;
   localparam mcs_state_t ST_LOAD     = 3'd1;
   localparam mcs_state_t ST_CONF     = 3'd2;
   localparam mcs_state_t ST_WAIT_ACK = 3'd3;
   localparam mcs_state_t ST_ACK      = 3'd4;
   localparam mcs_state_t ST_RUN      = 3'd5;

   typedef struct packed {
      logic [MCS_COLS_W_DEF-1:0] cols;
      logic [MCS_ROWS_W_DEF-1:0] rows;
   } mcs_desc_t;

   // Watchdog counter is at least 8 bits, wider if the limit needs it.
   function automatic int mcs_wd_width(input int limit);
      int w;
      w = $clog2(limit + 1);
      return (w < 8) ? 8 : w;
   endfunction

endpackage

// File: rtl/mcs_desc_fifo.sv
// -----------------------------------------------------------------------------
// mcs_desc_fifo
// Synchronous descriptor FIFO with full/empty flags. A push and a pop in the
// same cycle are both honoured, including when the FIFO is full (the popped
// slot makes room for the pushed entry). Pop on empty is ignored.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (flushes FIFO)
//   push, push_data     write request and descriptor bits
//   pop                 read request; pop_data shows the head entry
//   full, empty         occupancy flags
// -----------------------------------------------------------------------------
module mcs_desc_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] pop_data,
   output logic              full,
   output logic              empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q,  count_d;
   logic              do_push, do_pop;

   assign full     = (count_q == CNT_FULL);
   assign empty    = (count_q == '0);
   assign pop_data = mem_q[rd_ptr_q];

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Power-of-two depth: pointers wrap by natural overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/mux_conf_sequencer.sv
// -----------------------------------------------------------------------------
// mux_conf_sequencer
// Layer configuration sequencer upstream of MUXDC. Queues (cols, rows)
// descriptors, and for each one drives W_Colums and W_ROXCL = cols*rows-1,
// runs Set_Conf -> Set_Conf_Already -> Set_Conf_Already_Ok, then holds
// Layer_Ready until the compute engine reports Layer_Done.
// Build option:
//   MCS_TIMEOUT_EN  when defined, a watchdog in WAIT_ACK aborts the layer after
//                   TIMEOUT_CYCLES cycles without Set_Conf_Already and sets the
//                   sticky MCS_Error. The TIMEOUT_CYCLES parameter exists only
//                   in that build; otherwise MCS_Error is tied low.
// Ports:
//   MCS_Clk, MCS_Reset           clock, asynchronous active-low reset
//   MCS_Wr_En/_Colums/_Rows      descriptor write
//   MCS_Wr_Reject                one-cycle pulse after a dropped write
//   MCS_Full                     descriptor FIFO full
//   MCS_Start                    start processing the queue (from IDLE)
//   MCS_Set_Conf, MCS_W_Colums,
//   MCS_W_ROXCL                  configuration to MUXDC
//   MCS_Set_Conf_Already         MUXDC acknowledge (level)
//   MCS_Set_Conf_Already_Ok      one-cycle acknowledge-of-acknowledge
//   MCS_Layer_Ready, MCS_Layer_Done  compute engine handshake
//   MCS_Busy                     FSM not idle
//   MCS_Error                    sticky watchdog error
// -----------------------------------------------------------------------------
module mux_conf_sequencer
   import mcs_pkg::*;
#(
   parameter int BITWIDTH_W_COLUMS   = MCS_COLS_W_DEF,
   parameter int BITWIDTH_W_ROWS     = MCS_ROWS_W_DEF,
   parameter int BITWIDTH_MAX_W_SIZE = MCS_W_SIZE_W_DEF,
   parameter int DEPTH               = MCS_DEPTH_DEF
`ifdef MCS_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES      = 255
`endif
) (
   input  logic                           MCS_Clk,
   input  logic                           MCS_Reset,
   input  logic                           MCS_Wr_En,
   input  logic [BITWIDTH_W_COLUMS-1:0]   MCS_Wr_Colums,
   input  logic [BITWIDTH_W_ROWS-1:0]     MCS_Wr_Rows,
   output logic                           MCS_Wr_Reject,
   output logic                           MCS_Full,
   input  logic                           MCS_Start,
   output logic                           MCS_Set_Conf,
   output logic [BITWIDTH_W_COLUMS-1:0]   MCS_W_Colums,
   output logic [BITWIDTH_MAX_W_SIZE-1:0] MCS_W_ROXCL,
   input  logic                           MCS_Set_Conf_Already,
   output logic                           MCS_Set_Conf_Already_Ok,
   output logic                           MCS_Layer_Ready,
   input  logic                           MCS_Layer_Done,
   output logic                           MCS_Busy,
   output logic                           MCS_Error
);

   localparam int DESC_W = BITWIDTH_W_COLUMS + BITWIDTH_W_ROWS;
   // Products are evaluated at 33 bits so the size limit and the
   // full-width cols*rows never overflow before comparison/truncation.
   localparam logic [32:0] W_SIZE_LIMIT = 33'(1) << BITWIDTH_MAX_W_SIZE;

   mcs_state_t                     state_q, state_d;
   logic [BITWIDTH_W_COLUMS-1:0]   w_colums_q, w_colums_d;
   logic [BITWIDTH_MAX_W_SIZE-1:0] w_roxcl_q, w_roxcl_d;
   logic                           wr_reject_q, wr_reject_d;

   logic                           wr_nonzero, wr_fits, wr_accept;
   logic                           fifo_pop, fifo_full, fifo_empty;
   logic [DESC_W-1:0]              fifo_rd;
   logic [BITWIDTH_W_COLUMS-1:0]   rd_cols;
   logic [BITWIDTH_W_ROWS-1:0]     rd_rows;

   // Write filter. A write while full still succeeds if LOAD pops this cycle.
   assign wr_nonzero = (MCS_Wr_Colums != '0) && (MCS_Wr_Rows != '0);
   assign wr_fits    = ((33'(MCS_Wr_Colums) * 33'(MCS_Wr_Rows)) <= W_SIZE_LIMIT);
   assign fifo_pop   = (state_q == ST_LOAD);
   assign wr_accept  = MCS_Wr_En && wr_nonzero && wr_fits && (!fifo_full || fifo_pop);

   mcs_desc_fifo #(
      .DATA_W (DESC_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk       (MCS_Clk),
      .rst_n     (MCS_Reset),
      .push      (wr_accept),
      .push_data ({MCS_Wr_Colums, MCS_Wr_Rows}),
      .pop       (fifo_pop),
      .pop_data  (fifo_rd),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign rd_cols = fifo_rd[DESC_W-1:BITWIDTH_W_ROWS];
   assign rd_rows = fifo_rd[BITWIDTH_W_ROWS-1:0];

`ifdef MCS_TIMEOUT_EN
   localparam int WD_W = mcs_wd_width(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [WD_W-1:0] WD_ONE  = {{(WD_W-1){1'b0}}, 1'b1};

   logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
   logic            error_q, error_d;
`endif

   always_comb begin
      state_d     = state_q;
      w_colums_d  = w_colums_q;
      w_roxcl_d   = w_roxcl_q;
      wr_reject_d = MCS_Wr_En && !wr_accept;
`ifdef MCS_TIMEOUT_EN
      wd_cnt_d    = wd_cnt_q;
      error_d     = error_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (MCS_Start && !fifo_empty) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            w_colums_d = rd_cols;
            w_roxcl_d  = BITWIDTH_MAX_W_SIZE'(33'(rd_cols) * 33'(rd_rows) - 33'd1);
            state_d    = ST_CONF;
         end
         ST_CONF: begin
`ifdef MCS_TIMEOUT_EN
            wd_cnt_d = '0;
`endif
            state_d = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            if (MCS_Set_Conf_Already) begin
               state_d = ST_ACK;
`ifdef MCS_TIMEOUT_EN
            end else if (wd_cnt_q == WD_LAST) begin
               // Descriptor already popped in LOAD, so abandoning it drops it.
               error_d = 1'b1;
               state_d = ST_IDLE;
            end else begin
               wd_cnt_d = wd_cnt_q + WD_ONE;
`endif
            end
         end
         ST_ACK: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (MCS_Layer_Done) state_d = fifo_empty ? ST_IDLE : ST_LOAD;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge MCS_Clk or negedge MCS_Reset) begin
      if (!MCS_Reset) begin
         state_q     <= ST_IDLE;
         w_colums_q  <= '0;
         w_roxcl_q   <= '0;
         wr_reject_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         w_colums_q  <= w_colums_d;
         w_roxcl_q   <= w_roxcl_d;
         wr_reject_q <= wr_reject_d;
      end
   end

`ifdef MCS_TIMEOUT_EN
   always_ff @(posedge MCS_Clk or negedge MCS_Reset) begin
      if (!MCS_Reset) begin
         wd_cnt_q <= '0;
         error_q  <= 1'b0;
      end else begin
         wd_cnt_q <= wd_cnt_d;
         error_q  <= error_d;
      end
   end

   assign MCS_Error = error_q;
`else
   assign MCS_Error = 1'b0;
`endif

   // Handshake strobes decode straight from the state register, so a reset
   // drops them immediately and no stray Ok pulse can follow an abort.
   assign MCS_Set_Conf            = (state_q == ST_CONF);
   assign MCS_Set_Conf_Already_Ok = (state_q == ST_ACK);
   assign MCS_Layer_Ready         = (state_q == ST_RUN);
   assign MCS_Busy                = (state_q != ST_IDLE);
   assign MCS_W_Colums            = w_colums_q;
   assign MCS_W_ROXCL             = w_roxcl_q;
   assign MCS_Wr_Reject           = wr_reject_q;
   assign MCS_Full                = fifo_full;

endmodule
